// File: rtl/divider.sv
// Sequential unsigned divider by repeated subtraction: one subtract per clock,
// G start strobe, Z done flag, DZ divide-by-zero flag.
module divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             G,
  input  logic [WIDTH-1:0] LOADA,
  input  logic [WIDTH-1:0] LOADB,
  output logic [WIDTH-1:0] LOADQ,
  output logic [WIDTH-1:0] LOADR,
  output logic             Z,
  output logic             DZ,
  output logic             BUSY
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, q_q;
  logic [WIDTH-1:0] loadq_q, loadr_q;
  logic             z_q, dz_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      loadq_q <= '0;
      loadr_q <= '0;
      z_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // Published result holds until the next operation completes
          if (G) begin
            a_q     <= LOADA;
            b_q     <= LOADB;
            q_q     <= '0;
            z_q     <= 1'b0;
            dz_q    <= 1'b0;
            state_q <= DIV;
          end
        end
        DIV: begin
          if (b_q == '0) begin
            loadq_q <= '1;
            loadr_q <= a_q;
            dz_q    <= 1'b1;
            z_q     <= 1'b1;
            state_q <= DONE;
          end else if (a_q >= b_q) begin
            a_q <= a_q - b_q;
            q_q <= q_q + 1'b1;
          end else begin
            loadq_q <= q_q;
            loadr_q <= a_q;
            z_q     <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LOADQ = loadq_q;
  assign LOADR = loadr_q;
  assign Z     = z_q;
  assign DZ    = dz_q;
  assign BUSY  = (state_q == DIV);

endmodule

// File: tb/tb_divider.sv
// Randomized and directed bench for the repeated-subtraction divider,
// checked against plain integer division.
module tb_divider;
  localparam int W     = 8;
  localparam int LIMIT = 300;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         G;
  logic [W-1:0] LOADA, LOADB;
  logic [W-1:0] LOADQ, LOADR;
  logic         Z, DZ, BUSY;

  int checks   = 0;
  int failures = 0;
  int prev_q   = 0;
  int prev_r   = 0;

  divider #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .G(G), .LOADA(LOADA), .LOADB(LOADB),
    .LOADQ(LOADQ), .LOADR(LOADR), .Z(Z), .DZ(DZ), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Drive G for one accept edge; returns 1 time unit after that edge.
  task automatic start_op(input int a, input int b);
    @(negedge CLK);
    G = 1'b1; LOADA = W'(a); LOADB = W'(b);
    @(posedge CLK); #1;
    G = 1'b0; LOADA = 'x; LOADB = 'x;
  endtask

  // Count edges after the accept edge until Z rises (bounded).
  task automatic wait_done(output int edges, output int busy_gaps);
    edges = 0; busy_gaps = 0;
    while (Z !== 1'b1 && edges < LIMIT) begin
      @(posedge CLK); #1;
      edges++;
      if (Z !== 1'b1 && BUSY !== 1'b1) busy_gaps++;
    end
  endtask

  function automatic int mq(input int a, input int b);
    return (b == 0) ? (1 << W) - 1 : a / b;
  endfunction
  function automatic int mr(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction
  function automatic int mlat(input int a, input int b);
    return (b == 0) ? 1 : a / b + 1;
  endfunction

  task automatic test_reset();
    RESET_N = 1'b0; G = 1'b0; LOADA = '0; LOADB = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (LOADQ !== 0 || LOADR !== 0 || Z !== 0 || DZ !== 0 || BUSY !== 0) begin
      failures++;
      $display("FAIL reset_state: got Q=%0d R=%0d Z=%b DZ=%b BUSY=%b want all 0",
               LOADQ, LOADR, Z, DZ, BUSY);
    end
    @(negedge CLK); RESET_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (Z !== 0 || BUSY !== 0) begin
      failures++;
      $display("FAIL idle_hold: got Z=%b BUSY=%b want 0 0", Z, BUSY);
    end
  endtask

  task automatic test_normal();
    int e, gaps;
    start_op(23, 5);
    checks++;
    if (BUSY !== 1'b1 || Z !== 1'b0) begin
      failures++;
      $display("FAIL normal_accept: got BUSY=%b Z=%b want 1 0", BUSY, Z);
    end
    wait_done(e, gaps);
    checks++;
    if (e !== 5 || gaps !== 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL normal_latency: got edges=%0d gaps=%0d BUSY=%b want 5 0 0", e, gaps, BUSY);
    end
    checks++;
    if (LOADQ !== 4 || LOADR !== 3 || DZ !== 1'b0) begin
      failures++;
      $display("FAIL normal_result: got Q=%0d R=%0d DZ=%b want 4 3 0", LOADQ, LOADR, DZ);
    end
  endtask

  task automatic test_zero_dividend();
    int e, gaps;
    start_op(0, 7);
    wait_done(e, gaps);
    checks++;
    if (e !== 1 || LOADQ !== 0 || LOADR !== 0 || DZ !== 0) begin
      failures++;
      $display("FAIL zero_dividend: got edges=%0d Q=%0d R=%0d DZ=%b want 1 0 0 0", e, LOADQ, LOADR, DZ);
    end
  endtask

  task automatic test_div_zero();
    int e, gaps;
    start_op(9, 0);
    wait_done(e, gaps);
    checks++;
    if (e !== 1 || DZ !== 1 || LOADQ !== 255 || LOADR !== 9) begin
      failures++;
      $display("FAIL div_zero: got edges=%0d DZ=%b Q=%0d R=%0d want 1 1 255 9", e, DZ, LOADQ, LOADR);
    end
    start_op(10, 3);
    checks++;
    if (DZ !== 0 || Z !== 0 || LOADQ !== 255 || LOADR !== 9) begin
      failures++;
      $display("FAIL dz_clear_hold: got DZ=%b Z=%b Q=%0d R=%0d want 0 0 255 9", DZ, Z, LOADQ, LOADR);
    end
    wait_done(e, gaps);
    checks++;
    if (e !== 4 || LOADQ !== 3 || LOADR !== 1 || DZ !== 0) begin
      failures++;
      $display("FAIL after_dz: got edges=%0d Q=%0d R=%0d DZ=%b want 4 3 1 0", e, LOADQ, LOADR, DZ);
    end
  endtask

  task automatic test_worst_case();
    int e, gaps;
    start_op(255, 1);
    wait_done(e, gaps);
    checks++;
    if (e !== 256 || gaps !== 0 || LOADQ !== 255 || LOADR !== 0) begin
      failures++;
      $display("FAIL worst_case: got edges=%0d gaps=%0d Q=%0d R=%0d want 256 0 255 0", e, gaps, LOADQ, LOADR);
    end
    start_op(5, 9);
    wait_done(e, gaps);
    checks++;
    if (e !== 1 || LOADQ !== 0 || LOADR !== 5) begin
      failures++;
      $display("FAIL small_over_big: got edges=%0d Q=%0d R=%0d want 1 0 5", e, LOADQ, LOADR);
    end
  endtask

  task automatic test_g_busy();
    int e, gaps;
    start_op(200, 3);
    e = 0;
    while (Z !== 1'b1 && e < LIMIT) begin
      @(negedge CLK);
      G = (e == 3 || e == 4 || e == 20);
      LOADA = 8'd1; LOADB = 8'd1;
      @(posedge CLK); #1;
      e++;
    end
    G = 1'b0;
    checks++;
    if (e !== 67 || LOADQ !== 66 || LOADR !== 2) begin
      failures++;
      $display("FAIL g_ignored: got edges=%0d Q=%0d R=%0d want 67 66 2", e, LOADQ, LOADR);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (Z !== 1 || LOADQ !== 66 || LOADR !== 2 || BUSY !== 0) begin
      failures++;
      $display("FAIL done_hold: got Z=%b Q=%0d R=%0d BUSY=%b want 1 66 2 0", Z, LOADQ, LOADR, BUSY);
    end
    start_op(8, 2);
    checks++;
    if (Z !== 0 || BUSY !== 1) begin
      failures++;
      $display("FAIL b2b_accept: got Z=%b BUSY=%b want 0 1", Z, BUSY);
    end
    wait_done(e, gaps);
    checks++;
    if (e !== 5 || LOADQ !== 4 || LOADR !== 0) begin
      failures++;
      $display("FAIL b2b_result: got edges=%0d Q=%0d R=%0d want 5 4 0", e, LOADQ, LOADR);
    end
  endtask

  task automatic test_reset_mid();
    int e, gaps;
    start_op(100, 1);
    repeat (10) @(posedge CLK);
    #3 RESET_N = 1'b0;
    #1;
    checks++;
    if (BUSY !== 0 || Z !== 0 || DZ !== 0 || LOADQ !== 0 || LOADR !== 0) begin
      failures++;
      $display("FAIL reset_mid: got BUSY=%b Z=%b DZ=%b Q=%0d R=%0d want 0 0 0 0 0",
               BUSY, Z, DZ, LOADQ, LOADR);
    end
    @(negedge CLK); RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 0 || Z !== 0) begin
      failures++;
      $display("FAIL reset_idle: got BUSY=%b Z=%b want 0 0", BUSY, Z);
    end
    start_op(7, 2);
    wait_done(e, gaps);
    checks++;
    if (e !== 4 || LOADQ !== 3 || LOADR !== 1) begin
      failures++;
      $display("FAIL after_reset: got edges=%0d Q=%0d R=%0d want 4 3 1", e, LOADQ, LOADR);
    end
  endtask

  task automatic test_random();
    int a, b, e, gaps;
    prev_q = LOADQ; prev_r = LOADR;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      if (n % 5 == 0) b = $urandom_range(1, 4);
      start_op(a, b);
      checks++;
      if (Z !== 0 || DZ !== 0 || LOADQ !== W'(prev_q) || LOADR !== W'(prev_r)) begin
        failures++;
        $display("FAIL rand_accept[%0d]: got Z=%b DZ=%b Q=%0d R=%0d want 0 0 %0d %0d",
                 n, Z, DZ, LOADQ, LOADR, prev_q, prev_r);
      end
      wait_done(e, gaps);
      checks++;
      if (e !== mlat(a, b) || gaps !== 0 || LOADQ !== W'(mq(a, b)) ||
          LOADR !== W'(mr(a, b)) || DZ !== (b == 0)) begin
        failures++;
        $display("FAIL rand_op[%0d] %0d/%0d: got edges=%0d gaps=%0d Q=%0d R=%0d DZ=%b want %0d 0 %0d %0d %0d",
                 n, a, b, e, gaps, LOADQ, LOADR, DZ, mlat(a, b), mq(a, b), mr(a, b), (b == 0));
      end
      prev_q = mq(a, b); prev_r = mr(a, b);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_dividend();
    test_div_zero();
    test_worst_case();
    test_g_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
